// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and capture FSM type.
// Used by both the VGA driver and the sink-side capture logic.
package vga_timing_pkg;

  localparam int H_TOTAL_DEF = 800;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int H_ACT_DEF   = 640;
  localparam int V_TOTAL_DEF = 525;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int V_ACT_DEF   = 480;

  localparam logic [9:0] POS_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } cap_state_t;

  // Position counters stick at the top value rather than wrapping.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == POS_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Video-in / pixel-out bundle for vga_capture.
// master = stream source and pixel consumer, slave = the capture block.
interface vga_capture_if;
  import vga_timing_pkg::*;

  logic        hys;
  logic        vys;
  logic [15:0] lcd_rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        locked;
  logic [7:0]  err_cnt;

  modport master (
    output hys, vys, lcd_rgb,
    input  pix_valid, pix_x, pix_y, pix_data, frame_start, locked, err_cnt
  );

  modport slave (
    input  hys, vys, lcd_rgb,
    output pix_valid, pix_x, pix_y, pix_data, frame_start, locked, err_cnt
  );

endinterface

// File: rtl/sync_edge_det.sv
// Registers an active-low sync input and flags its falling edge.
// fall is high for exactly one cycle, the first cycle sync reads 0.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic fall
);

  logic dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 1'b1;
      dly  <= 1'b1;
    end else begin
      sync <= d;
      dly  <= sync;
    end
  end

  assign fall = dly & ~sync;

endmodule

// File: rtl/vga_capture.sv
// Sink-side VGA timing recovery: verifies sync cadence, then emits
// qualified pixels with x/y coordinates two clocks after sampling.
//
//   state   | meaning
//   SEARCH  | waiting for a frame start
//   MEASURE | checking one full frame of line/frame periods
//   LOCKED  | timing verified, pixels qualified
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  vga_capture_if.slave   vif
);

  localparam logic [9:0] H_OFF  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END  = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_OFF  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END  = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_TMO  = 10'(H_TOTAL);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic        s_hys;
  logic        ls;
  logic        s_vys;
  logic        v_hist;
  logic [15:0] s_rgb;
  logic [9:0]  h_pos;
  logic [9:0]  v_pos;
  logic        h_end;
  logic        armed;
  logic        fs;
  logic        line_bad;
  logic        frame_bad;
  logic        err_evt;
  logic        active;
  logic        valid_d;
  cap_state_t  state;
  cap_state_t  state_d;

  sync_edge_det u_hys_det (
    .clk  (clk),
    .rst  (rst),
    .d    (vif.hys),
    .sync (s_hys),
    .fall (ls)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_vys  <= 1'b1;
      v_hist <= 1'b1;
      s_rgb  <= '0;
    end else begin
      s_vys <= vif.vys;
      s_rgb <= vif.lcd_rgb;
      if (ls) v_hist <= s_vys;
    end
  end

  // h_pos clears on the edge that makes LS visible, so it is 0 in the LS
  // cycle and stays aligned with s_rgb for the rest of the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_pos <= '0;
      h_end <= 1'b0;
      v_pos <= '0;
    end else begin
      h_pos <= (s_hys && !vif.hys) ? 10'd0 : sat_inc(h_pos);
      h_end <= (h_pos == H_LAST);
      if (fs)      v_pos <= '0;
      else if (ls) v_pos <= sat_inc(v_pos);
    end
  end

  assign fs        = ls && !s_vys && v_hist;
  assign line_bad  = armed && ((ls && !h_end) || (h_pos == H_TMO));
  assign frame_bad = fs && (v_pos != V_LAST);
  assign active    = (h_pos >= H_OFF) && (h_pos < H_END) &&
                     (v_pos >= V_OFF) && (v_pos < V_END);
  assign valid_d   = (state == LOCKED) && active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_d;
  end

  // A coincident bad line and bad frame raise a single error event.
  always_comb begin
    state_d = state;
    err_evt = 1'b0;
    case (state)
      SEARCH: begin
        if (fs) state_d = MEASURE;
      end
      MEASURE: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          err_evt = 1'b1;
        end else if (fs) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          err_evt = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // The line in progress at MEASURE entry may be partial, so line checks
  // wait for the first LS seen inside MEASURE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else if (state_d == SEARCH) begin
      armed <= 1'b0;
    end else if (ls && (state == MEASURE)) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vif.pix_valid   <= 1'b0;
      vif.pix_x       <= '0;
      vif.pix_y       <= '0;
      vif.pix_data    <= '0;
      vif.frame_start <= 1'b0;
      vif.locked      <= 1'b0;
      vif.err_cnt     <= '0;
    end else begin
      vif.pix_valid   <= valid_d;
      vif.pix_x       <= valid_d ? (h_pos - H_OFF) : 10'd0;
      vif.pix_y       <= valid_d ? (v_pos - V_OFF) : 10'd0;
      vif.pix_data    <= valid_d ? s_rgb : 16'd0;
      vif.frame_start <= valid_d && (h_pos == H_OFF) && (v_pos == V_OFF);
      vif.locked      <= (state_d == LOCKED);
      if (err_evt && (vif.err_cnt != 8'hFF)) vif.err_cnt <= vif.err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster; pixels are
// scoreboarded from the driver and matched against the DUT output.
module tb_vga_capture;

  localparam int HT   = 20;
  localparam int HS   = 2;
  localparam int HB   = 3;
  localparam int HA   = 12;
  localparam int VT   = 12;
  localparam int VS   = 2;
  localparam int VB   = 2;
  localparam int VA   = 6;
  localparam int HOFF = HS + HB;
  localparam int VOFF = VS + VB;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
  } px_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_capture_if vif ();

  vga_capture #(
    .H_TOTAL (HT), .H_SYNC (HS), .H_BP (HB), .H_ACT (HA),
    .V_TOTAL (VT), .V_SYNC (VS), .V_BP (VB), .V_ACT (VA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  px_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   fs_cnt = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   fs_drive_cyc = 0;
  logic prev_locked = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of raster at position (h,v); active pixels carry {y[5:0],x}.
  task automatic drive_clk(input int h, input int v, input bit push);
    px_t p;
    @(negedge clk);
    if (h == 0 && v == 0) fs_drive_cyc = cyc;
    vif.hys = (h < HS) ? 1'b0 : 1'b1;
    vif.vys = (v < VS) ? 1'b0 : 1'b1;
    if (h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA) begin
      p.x = 10'(h - HOFF);
      p.y = 10'(v - VOFF);
      p.d = {p.y[5:0], p.x};
      vif.lcd_rgb = p.d;
      if (push) sb.push_back(p);
    end else begin
      vif.lcd_rgb = 16'hA5A5;
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_v, input int push_below);
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < ((v == short_v) ? HT - 1 : HT); h++) begin
        drive_clk(h, v, v < push_below);
      end
    end
  endtask

  always @(negedge clk) begin
    px_t p;
    if (vif.pix_valid === 1'b1) begin
      valid_cnt++;
      chk("pix_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        p = sb.pop_front();
        chk("pix_x", 64'(vif.pix_x), 64'(p.x));
        chk("pix_y", 64'(vif.pix_y), 64'(p.y));
        chk("pix_data", 64'(vif.pix_data), 64'(p.d));
        chk("frame_start", 64'(vif.frame_start), 64'(p.x == 10'd0 && p.y == 10'd0));
      end
    end
    if (vif.frame_start === 1'b1) fs_cnt++;
    if (vif.locked === 1'b1 && prev_locked === 1'b0) rise_cyc = cyc;
    if (vif.locked === 1'b0 && prev_locked === 1'b1) fall_cyc = cyc;
    prev_locked = vif.locked;
  end

  initial begin
    rst         = 1'b0;
    vif.hys     = 1'b1;
    vif.vys     = 1'b1;
    vif.lcd_rgb = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", 64'(vif.pix_valid), 64'd0);
    chk("rst_pix_x", 64'(vif.pix_x), 64'd0);
    chk("rst_pix_y", 64'(vif.pix_y), 64'd0);
    chk("rst_pix_data", 64'(vif.pix_data), 64'd0);
    chk("rst_frame_start", 64'(vif.frame_start), 64'd0);
    chk("rst_locked", 64'(vif.locked), 64'd0);
    chk("rst_err_cnt", 64'(vif.err_cnt), 64'd0);
    rst = 1'b1;

    // nominal lock: first FS starts measurement, second FS locks
    drive_frame(VT, -1, 0);
    chk("locked_after_f1", 64'(vif.locked), 64'd0);
    drive_frame(VT, -1, 99);
    chk("lock_rise_lat", 64'(rise_cyc - fs_drive_cyc), 64'd2);
    chk("locked_f2", 64'(vif.locked), 64'd1);
    valid_cnt = 0;
    fs_cnt    = 0;
    drive_frame(VT, -1, 99);
    chk("valid_per_frame", 64'(valid_cnt), 64'(HA * VA));
    chk("fs_per_frame", 64'(fs_cnt), 64'd1);
    chk("sb_drain_nom", 64'(sb.size()), 64'd0);
    chk("err_nom", 64'(vif.err_cnt), 64'd0);

    // short line while locked
    drive_frame(VT, 5, 6);
    chk("short_locked", 64'(vif.locked), 64'd0);
    chk("short_err", 64'(vif.err_cnt), 64'd1);
    chk("sb_drain_short", 64'(sb.size()), 64'd0);
    drive_frame(VT, -1, 0);
    chk("short_measure", 64'(vif.locked), 64'd0);
    drive_frame(VT, -1, 99);
    chk("short_relock", 64'(vif.locked), 64'd1);
    chk("short_err_hold", 64'(vif.err_cnt), 64'd1);

    // extra line: 13-line frame fails at the following FS
    drive_frame(VT + 1, -1, 99);
    chk("extra_still_locked", 64'(vif.locked), 64'd1);
    drive_frame(VT, -1, 0);
    chk("extra_drop_lat", 64'(fall_cyc - fs_drive_cyc), 64'd2);
    chk("extra_locked", 64'(vif.locked), 64'd0);
    chk("extra_err", 64'(vif.err_cnt), 64'd2);
    chk("sb_drain_extra", 64'(sb.size()), 64'd0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 99);
    chk("extra_relock", 64'(vif.locked), 64'd1);

    // stuck hsync
    repeat (2000) drive_clk(HT - 1, VT - 1, 1'b0);
    chk("stuck_err", 64'(vif.err_cnt), 64'd3);
    chk("stuck_locked", 64'(vif.locked), 64'd0);
    chk("stuck_h_sat", 64'(dut.h_pos), 64'h3FF);

    // mid-frame reset
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 99);
    chk("prereset_locked", 64'(vif.locked), 64'd1);
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < HT; h++) drive_clk(h, v, 1'b1);
    end
    for (int h = 0; h < HT; h++) begin
      drive_clk(h, 6, 1'b0);
      if (h == 1) rst = 1'b0;
      if (h == 4) rst = 1'b1;
      if (rst == 1'b0) begin
        #1;
        chk("rst_mid_outputs", 64'({vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_data,
                                    vif.frame_start, vif.locked, vif.err_cnt}), 64'd0);
      end
    end
    for (int v = 7; v < VT; v++) begin
      for (int h = 0; h < HT; h++) drive_clk(h, v, 1'b0);
    end
    drive_frame(VT, -1, 0);
    chk("postreset_measure", 64'(vif.locked), 64'd0);
    chk("postreset_err", 64'(vif.err_cnt), 64'd0);
    drive_frame(VT, -1, 99);
    chk("postreset_relock", 64'(vif.locked), 64'd1);
    chk("sb_drain_reset", 64'(sb.size()), 64'd0);

    // error saturation: each 3-line frame has a short second line
    for (int i = 0; i < 300; i++) begin
      drive_frame(3, 1, 0);
      if (i == 253) chk("sat_err_254", 64'(vif.err_cnt), 64'd254);
    end
    chk("sat_err_255", 64'(vif.err_cnt), 64'd255);
    chk("sat_locked", 64'(vif.locked), 64'd0);
    chk("sb_drain_end", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
